// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-channel round-robin mux arbiter:
// channel count, select width, FSM states and the rotating-priority search.
package mux8_arb_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Search req from ptr+1 upward, modulo N_CH. The ptr channel itself is
    // visited last (offset N_CH), so a current owner only wins when no
    // other channel is requesting. The loop runs from the farthest offset to
    // the nearest one. Each later hit overwrites an earlier one, so the
    // nearest requester is the value left at the end.
    function automatic pick_t rr_pick(input logic [N_CH-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux8_w.sv
// W-bit 8:1 multiplexer with an enable.
// The output is all-zero when en is low or the select is out of range.
module mux8_w #(
    parameter int W = 1
) (
    input  logic [2:0]   sel,
    input  logic         en,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [W-1:0] d4,
    input  logic [W-1:0] d5,
    input  logic [W-1:0] d6,
    input  logic [W-1:0] d7,
    output logic [W-1:0] f
);

    // Select the addressed channel, or zero when disabled.
    always_comb begin
        f = '0;
        if (en) begin
            case (sel)
                3'd0:    f = d0;
                3'd1:    f = d1;
                3'd2:    f = d2;
                3'd3:    f = d3;
                3'd4:    f = d4;
                3'd5:    f = d5;
                3'd6:    f = d6;
                3'd7:    f = d7;
                default: f = '0;
            endcase
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 8:1 mux.
// An owner keeps the grant while it requests, up to MAX_HOLD consecutive
// cycles. At that point the grant rotates to the next requester.
// Optional feature: the macro MUX8_ARB_LOCK_EN adds a lock input. While lock
// is high, the owner is not preempted by the hold timeout.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic [W-1:0]     d4,
    input  logic [W-1:0]     d5,
    input  logic [W-1:0]     d6,
    input  logic [W-1:0]     d7,
`ifdef MUX8_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [W-1:0]     f
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t           state_reg, state_next;
    logic [N_CH-1:0]  gnt_reg,   gnt_next;
    logic [SEL_W-1:0] sel_reg,   sel_next;
    logic             busy_reg,  busy_next;
    logic [7:0]       cnt_reg,   cnt_next;
    logic [SEL_W-1:0] ptr_reg,   ptr_next;

    pick_t pick;
    logic  owner_req;
    logic  hold_lock;

`ifdef MUX8_ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    assign pick      = rr_pick(req, ptr_reg);
    assign owner_req = req[sel_reg];

    // Register all arbitration state. Reset parks ptr at 7 so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            ptr_reg   <= SEL_W'(N_CH - 1);
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Compute the next state: grant, keep, hand over or release.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        busy_next  = busy_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;

        case (state_reg)
            IDLE: begin
                if (pick.valid) begin
                    state_next = OWN;
                    gnt_next   = N_CH'(1) << pick.idx;
                    sel_next   = pick.idx;
                    busy_next  = 1'b1;
                    cnt_next   = 8'd1;
                    ptr_next   = pick.idx;
                end
            end
            OWN: begin
                if (owner_req && (cnt_reg < MAX_HOLD_C)) begin
                    // Owner still within its hold budget.
                    cnt_next = cnt_reg + 8'd1;
                end else if (owner_req && hold_lock) begin
                    // The timeout is suppressed, so the counter stays saturated.
                    cnt_next = MAX_HOLD_C;
                end else if (pick.valid) begin
                    // Release or timeout: hand over with no idle cycle. On a
                    // timeout, pick reaches the owner only as a last resort.
                    gnt_next  = N_CH'(1) << pick.idx;
                    sel_next  = pick.idx;
                    busy_next = 1'b1;
                    cnt_next  = 8'd1;
                    ptr_next  = pick.idx;
                end else begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    sel_next   = '0;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                sel_next   = '0;
                busy_next  = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign busy = busy_reg;

    mux8_w #(.W(W)) u_mux (
        .sel (sel_reg),
        .en  (busy_reg),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7),
        .f   (f)
    );

endmodule
